// File: rtl/sevenseg_capture.sv
`timescale 1ns/1ps
// sevenseg_capture
//   Receive side of a multiplexed 8-digit seven-segment interface. Samples the
//   anode, segment and decimal-point lines, waits for the anode to settle, and
//   decodes the segment pattern back into a BCD nibble for the selected digit.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active-low
//   an_l       anode enables, active-low, bit i selects digit i
//   segs_l     segment lines, active-low, bit0=a .. bit6=g
//   dp_l       decimal point, active-low
//   d0..d7     decoded digit values
//   dp         decimal point per digit, active-high
//   valid      per-digit flag: last capture of that digit decoded cleanly
//   frame_done one-cycle pulse when all 8 digits have been captured
//   err        one-cycle pulse on an illegal pattern or multi-hot anode
module sevenseg_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] an_l,
  input  logic [6:0] segs_l,
  input  logic       dp_l,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [3:0] d4,
  output logic [3:0] d5,
  output logic [3:0] d6,
  output logic [3:0] d7,
  output logic [7:0] dp,
  output logic [7:0] valid,
  output logic       frame_done,
  output logic       err
);

  localparam logic [7:0] STB = STABLE_CYCLES[7:0];

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  // Input synchronizers (idle-high so reset looks like "no digit selected")
  logic [7:0] an_m, a_s;
  logic [6:0] seg_m, s_s;
  logic       dp_m, p_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_m  <= '1;
      a_s   <= '1;
      seg_m <= '1;
      s_s   <= '1;
      dp_m  <= 1'b1;
      p_s   <= 1'b1;
    end else begin
      an_m  <= an_l;
      a_s   <= an_m;
      seg_m <= segs_l;
      s_s   <= seg_m;
      dp_m  <= dp_l;
      p_s   <= dp_m;
    end
  end

  // Anode classification
  logic [7:0] sel;
  logic       is_zero, is_multi, is_one;
  logic [2:0] sel_k;

  always_comb begin
    sel      = ~a_s;
    is_zero  = (sel == 8'h00);
    is_multi = ((sel & (sel - 8'd1)) != 8'h00);
    is_one   = !is_zero && !is_multi;
    sel_k    = 3'd0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (sel[i]) sel_k = i[2:0];
    end
  end

  // FSM
  state_t     state, state_nx;
  logic [2:0] cur_k, k_nx;
  logic [7:0] cnt, cnt_nx;
  logic       capture, multi_err, prev_multi;
  logic       start_new, count_up;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cur_k <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cur_k <= k_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    k_nx      = cur_k;
    cnt_nx    = cnt;
    capture   = 1'b0;
    start_new = 1'b0;
    count_up  = 1'b0;
    // A held multi-hot anode reports once, on entry
    multi_err = is_multi && !prev_multi;

    unique case (state)
      IDLE: begin
        if (is_one) start_new = 1'b1;
      end
      SETTLE: begin
        if (is_one) begin
          if (sel_k == cur_k) count_up = 1'b1;
          else                start_new = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      HELD: begin
        if (is_one) begin
          if (sel_k != cur_k) start_new = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Loading a new digit counts as its first stable sample, so a threshold
    // of 1 captures on the very edge the digit appears.
    if (start_new) begin
      k_nx   = sel_k;
      cnt_nx = 8'd1;
      if (STB == 8'd1) begin
        capture  = 1'b1;
        state_nx = HELD;
      end else begin
        state_nx = SETTLE;
      end
    end else if (count_up) begin
      cnt_nx = cnt + 8'd1;
      if (cnt + 8'd1 == STB) begin
        capture  = 1'b1;
        state_nx = HELD;
      end
    end
  end

  // Segment decode (active-high gfedcba)
  logic [6:0] pat;
  logic [3:0] dec_val;
  logic       dec_ok;

  always_comb begin
    pat     = ~s_s;
    dec_ok  = 1'b1;
    dec_val = 4'h0;
    unique case (pat)
      7'h3F: dec_val = 4'd0;
      7'h06: dec_val = 4'd1;
      7'h5B: dec_val = 4'd2;
      7'h4F: dec_val = 4'd3;
      7'h66: dec_val = 4'd4;
      7'h6D: dec_val = 4'd5;
      7'h7D: dec_val = 4'd6;
      7'h07: dec_val = 4'd7;
      7'h7F: dec_val = 4'd8;
      7'h6F: dec_val = 4'd9;
      7'h00: dec_val = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  // Captured digit storage and frame tracking
  logic [3:0] dig [8];
  logic [7:0] seen, cap_bit, seen_nx;

  always_comb begin
    cap_bit = 8'b1 << k_nx;
    seen_nx = seen | cap_bit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 8; i++) dig[i] <= '0;
      dp         <= '0;
      valid      <= '0;
      seen       <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      prev_multi <= 1'b0;
    end else begin
      prev_multi <= is_multi;
      err        <= multi_err || (capture && !dec_ok);
      frame_done <= 1'b0;
      if (capture) begin
        if (dec_ok) dig[k_nx] <= dec_val;
        valid[k_nx] <= dec_ok;
        dp[k_nx]    <= ~p_s;
        if (seen_nx == 8'hFF) begin
          frame_done <= 1'b1;
          seen       <= '0;
        end else begin
          seen <= seen_nx;
        end
      end
    end
  end

  assign d0 = dig[0];
  assign d1 = dig[1];
  assign d2 = dig[2];
  assign d3 = dig[3];
  assign d4 = dig[4];
  assign d5 = dig[5];
  assign d6 = dig[6];
  assign d7 = dig[7];

endmodule

// File: tb/tb_sevenseg_capture.sv
`timescale 1ns/1ps
// Testbench for sevenseg_capture: dwell-based stimulus with a reference model
// that predicts each visible output event and its cycle; a monitor compares.
module tb_sevenseg_capture;

  localparam int unsigned S = 4;
  localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] an_l;
  logic [6:0] segs_l;
  logic       dp_l;
  logic [3:0] d0, d1, d2, d3, d4, d5, d6, d7;
  logic [7:0] dp, valid;
  logic       frame_done, err;

  sevenseg_capture #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .an_l(an_l), .segs_l(segs_l), .dp_l(dp_l),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7),
    .dp(dp), .valid(valid), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] dv;
    logic [7:0]  dp;
    logic [7:0]  valid;
    logic        err;
    logic        fd;
  } ev_t;

  ev_t sb_q [$];
  int  checks = 0;
  int  errors = 0;

  // Reference state
  logic [3:0] md [8];
  logic [7:0] mdp, mval, mseen;
  bit         mprev_multi;
  logic [7:0] prev_an;

  function automatic logic [31:0] pack_model();
    logic [31:0] v;
    for (int i = 0; i < 8; i++) v[4*i +: 4] = md[i];
    return v;
  endfunction

  function automatic logic [4:0] decode(input logic [6:0] p);
    if (p == 7'h00) return {1'b1, 4'hF};
    for (int j = 0; j < 10; j++) if (PAT[j] == p) return {1'b1, 4'(j)};
    return 5'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) md[i] = 4'h0;
    mdp = '0; mval = '0; mseen = '0; mprev_multi = 0;
  endtask

  // Predict and then drive one dwell of length len starting now
  task automatic dwell(input logic [7:0] an, input logic [6:0] pat,
                       input logic dpl, input int unsigned len);
    logic [7:0]  sel;
    logic [31:0] old_dv;
    logic [7:0]  old_dp, old_val;
    logic [4:0]  dec;
    int          k;
    bit          fd;
    ev_t         e;
    sel = ~an;
    if ($countones(sel) > 1) begin
      if (!mprev_multi) begin
        e = '{cyc: cyc + 3, dv: pack_model(), dp: mdp, valid: mval, err: 1'b1, fd: 1'b0};
        sb_q.push_back(e);
      end
      mprev_multi = 1;
    end else begin
      mprev_multi = 0;
      if (sel != 0 && len >= S) begin
        k = 0;
        for (int i = 0; i < 8; i++) if (sel[i]) k = i;
        old_dv = pack_model(); old_dp = mdp; old_val = mval;
        dec = decode(pat);
        if (dec[4]) md[k] = dec[3:0];
        mval[k] = dec[4];
        mdp[k]  = ~dpl;
        mseen[k] = 1'b1;
        fd = (mseen == 8'hFF);
        if (fd) mseen = '0;
        if (fd || !dec[4] || old_dv != pack_model() || old_dp != mdp || old_val != mval) begin
          e = '{cyc: cyc + 2 + S, dv: pack_model(), dp: mdp, valid: mval,
                err: !dec[4], fd: fd};
          sb_q.push_back(e);
        end
      end
    end
    an_l = an; segs_l = ~pat; dp_l = dpl; prev_an = an;
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic sweep();
    for (int i = 0; i < 8; i++)
      dwell(~(8'b1 << i), PAT[(i + 1) % 10], (i == 2) ? 1'b0 : 1'b1, 8);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  logic [31:0] out_dv;
  assign out_dv = {d7, d6, d5, d4, d3, d2, d1, d0};

  initial begin
    logic [7:0]  an;
    logic [6:0]  pat;
    logic [47:0] last_snap, snap;
    int unsigned r;
    ev_t         e;

    rst = 1'b0; an_l = '1; segs_l = '1; dp_l = 1'b1; prev_an = '1;
    model_reset();

    fork
      begin : monitor
        last_snap = '0;
        forever begin
          @(negedge clk);
          if (!rst) begin
            last_snap = '0;
          end else begin
            snap = {out_dv, dp, valid};
            if (err || frame_done || snap != last_snap) begin
              checks++;
              if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d got dv=%h dp=%h valid=%h err=%b fd=%b exp none",
                         cyc, out_dv, dp, valid, err, frame_done);
              end else begin
                e = sb_q.pop_front();
                if (e.cyc != cyc || e.dv !== out_dv || e.dp !== dp || e.valid !== valid ||
                    e.err !== err || e.fd !== frame_done) begin
                  errors++;
                  $display("FAIL event got cyc=%0d dv=%h dp=%h valid=%h err=%b fd=%b exp cyc=%0d dv=%h dp=%h valid=%h err=%b fd=%b",
                           cyc, out_dv, dp, valid, err, frame_done,
                           e.cyc, e.dv, e.dp, e.valid, e.err, e.fd);
                end
              end
              last_snap = snap;
            end
          end
        end
      end
      begin : watchdog
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
      end
    join_none

    #12;
    check("reset_outputs", {out_dv, dp, valid, err, frame_done}, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Full "12345678" sweep, decimal point on digit 2
    sweep();
    // Short dwell on digit 3 must not capture
    dwell(~8'h08, PAT[9], 1'b1, 3);
    dwell(~8'h10, PAT[4], 1'b1, 8);
    dwell(~8'h08, PAT[9], 1'b1, 8);
    // Multi-hot anode held
    dwell(8'b1111_0011, PAT[0], 1'b1, 10);
    // Illegal pattern on digit 5, then a clean zero
    dwell(~8'h20, 7'b0001000, 1'b1, 8);
    dwell(~8'h10, PAT[4], 1'b1, 8);
    dwell(~8'h20, PAT[0], 1'b1, 8);
    // Blank on digit 1
    dwell(~8'h02, 7'h00, 1'b1, 8);
    dwell(8'hFF, 7'h00, 1'b1, 3);

    // Randomized dwells
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 99);
      do begin
        if (r < 8) an = 8'hFF;
        else if (r < 16 && !mprev_multi) begin
          do an = 8'($urandom_range(0, 255)); while ($countones(~an) < 2);
        end else an = ~(8'b1 << $urandom_range(0, 7));
      end while (an == prev_an);
      r = $urandom_range(0, 11);
      if (r < 10) pat = PAT[r];
      else if (r == 10) pat = 7'h00;
      else pat = 7'($urandom_range(0, 127));
      dwell(an, pat, 1'($urandom_range(0, 1)), $urandom_range(1, 10));
    end
    dwell(8'hFF, 7'h00, 1'b1, 8);

    // Reset in the middle of settling on digit 6
    an_l = ~8'h40; segs_l = ~PAT[6]; dp_l = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1 check("async_reset", {out_dv, dp, valid, err, frame_done}, '0);
    check("pending_before_reset", 64'(sb_q.size()), 64'd0);
    an_l = '1; segs_l = '1; dp_l = 1'b1; prev_an = '1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    sweep();
    dwell(8'hFF, 7'h00, 1'b1, S + 6);

    check("queue_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_capture.md
Name: sevenseg_capture

Overview:
- Receive end of the multiplexed seven-segment display interface: samples the anode, segment and decimal-point lines that the display controller drives, and rebuilds the eight BCD digits.
- Used as a self-check monitor in the stopwatch build and as a bench checker.
- Ignores ghosting and transitions while the anode is switching, decodes segment patterns back to nibbles, and reports when a complete refresh frame has been seen.

Parameters:
- STABLE_CYCLES, 4: consecutive synchronized samples that must show the same one-hot anode before a capture. Legal range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- an_l  in  8  anode enables, active-low; bit i selects digit i
- segs_l  in  7  segment lines, active-low; bit0=a, bit1=b, ... bit6=g
- dp_l  in  1  decimal point, active-low
- d0..d7  out  4 each  decoded digit i
- dp  out  8  decimal point per digit, active-high
- valid  out  8  valid[i]=1 when the last capture of digit i decoded cleanly
- frame_done  out  1  one-cycle pulse when all 8 digits have been captured since the previous pulse
- err  out  1  one-cycle pulse on an illegal pattern or a multi-hot anode

Behaviour:
- Reset (rst=0, async) values:
  - d0..d7=4'h0, dp=0, valid=0, frame_done=0, err=0.
  - seen mask=0, state=IDLE, stability counter=0, synchronizer flops=all 1s.
- Synchronization:
  - an_l, segs_l and dp_l pass through 2-flop synchronizers.
  - All decisions below use the synchronized values (a_s, s_s, p_s).
- Anode classification of ~a_s:
  - zero: no digit selected.
  - one-hot: index k.
  - multi-hot: more than one digit selected.
- FSM:
  - IDLE:
    - one-hot → SETTLE; load k, counter=1.
    - multi-hot → err pulse, stay IDLE.
  - SETTLE:
    - Same one-hot k → counter+1.
    - When the counter reaches STABLE_CYCLES, capture on that edge and go to HELD.
    - Different one-hot → reload k, counter=1, stay SETTLE.
    - Zero → IDLE.
    - Multi-hot → err pulse, IDLE.
  - HELD:
    - Same k → stay; no further captures during this dwell.
    - Different one-hot → SETTLE with new k, counter=1.
    - Zero → IDLE.
    - Multi-hot → err pulse, IDLE.
  - With STABLE_CYCLES=1, the capture occurs on the first edge the one-hot value is seen.
- Capture of digit k:
  - Decode ~s_s as active-high gfedcba:
    - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9.
    - 00 (blank)→4'hF.
  - Decoded pattern: dk=value, valid[k]=1.
  - Any other pattern: dk unchanged, valid[k]=0, err pulses on the capture edge.
  - In both cases dp[k]=~p_s and seen[k]=1.
- Latency: the output updates on the edge that is 2 (synchronizer) + STABLE_CYCLES clocks after the anode change reaches the input pins.
- Frame:
  - When a capture makes seen==8'hFF, frame_done pulses on that same edge and seen clears to 0.
  - Recapturing an already-seen digit does not advance the frame.
- Simultaneous events: an illegal pattern on the capture that completes a frame pulses both err and frame_done.
- Reset mid-dwell: outputs clear immediately; capture resumes from IDLE after the synchronizers refill.
- Outputs are registered. err and frame_done are never high for 2 consecutive cycles from a single event.

Test Plan:
- STABLE_CYCLES=4. Drive digits 0..7 showing "12345678", each with an 8-cycle dwell, dp_l=0 on digit 2 only.
  - d0..d7 = 1..8, dp=8'h04, valid=8'hFF.
  - Exactly one frame_done, on the digit 7 capture.
- Digit 3 dwell of only 3 cycles (STABLE_CYCLES=4) carrying "9".
  - No capture; d3 retains its prior value.
  - No frame_done until a later 4+ cycle dwell on digit 3.
- an_l=8'b1111_0011 held for 10 cycles.
  - err pulses exactly once.
  - No output change; FSM returns to IDLE.
- Digit 5 with segs_l=7'b1110111 (only segment d lit).
  - err pulses on the capture edge; valid[5]=0; d5 unchanged.
  - Next clean "0" on digit 5 gives valid[5]=1, d5=0.
- Blank pattern (segs_l=7'h7F) on digit 1 → d1=4'hF, valid[1]=1, no err.
- Assert rst low mid-SETTLE on digit 6.
  - All outputs go to reset values asynchronously.
  - After release, a full 8-digit sweep produces frame_done.
